// File: rtl/fp_vector_stream_arbiter.sv
// Round-robin arbiter that captures one NUM_REQ-way FP vector and serializes it element by element.
// Optional FP_STREAM_SPECIAL_FLAG_EN adds a NaN/Inf flag and a saturating count of flagged elements.
module fp_vector_stream_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LENGTH  = 3,
  parameter int WIDTH   = 32,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int IDX_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*LENGTH*WIDTH-1:0]   req_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic                              out_last,
  output logic [SRC_W-1:0]                  out_src,
  output logic [IDX_W-1:0]                  out_index,
  output logic                              busy
`ifdef FP_STREAM_SPECIAL_FLAG_EN
  ,
  output logic                              out_special,
  output logic [15:0]                       special_count
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   buf_q [LENGTH];
  logic [WIDTH-1:0]   buf_d [LENGTH];
  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   grant_next;
  logic [NUM_REQ-1:0] req_ready_int;

  // Two passes: first requesters at or above rr_ptr, then the wrapped-around ones below it.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!grant_found && req_valid[r] && (r >= int'(rr_ptr_q))) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(r);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!grant_found && req_valid[r]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(r);
      end
    end
    grant_next = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    src_d         = src_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    req_ready_int = '0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;
    out_index     = '0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_int[grant_idx] = 1'b1;
          for (int i = 0; i < LENGTH; i++) begin
            buf_d[i] = req_data[(int'(grant_idx) * LENGTH + i) * WIDTH +: WIDTH];
          end
          src_d    = grant_idx;
          idx_d    = '0;
          rr_ptr_d = grant_next;
          state_d  = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = buf_q[idx_q];
        out_index = idx_q;
        out_last  = (idx_q == IDX_W'(LENGTH - 1));
        busy      = 1'b1;
        if (out_ready) begin
          if (out_last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = rst_n ? req_ready_int : '0;
  assign out_src   = src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      idx_q    <= '0;
      for (int i = 0; i < LENGTH; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
    end
  end

`ifdef FP_STREAM_SPECIAL_FLAG_EN
  logic [15:0] special_count_q, special_count_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // All-ones exponent marks NaN or infinity.
  always_comb begin
    out_special     = out_valid && (out_data[30:23] == 8'hFF);
    special_count_d = (out_special && out_ready) ? sat_inc16(special_count_q) : special_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) special_count_q <= '0;
    else        special_count_q <= special_count_d;
  end

  assign special_count = special_count_q;
`endif

endmodule
